// File: rtl/input_debouncer_2ch.sv
// Two-channel synchroniser + debouncer feeding or_gate; out follows raw DEBOUNCE_CYCLES+2 edges after a held change, no backpressure.
// Optional rejected-glitch counter port glitch_cnt is enabled by defining DEBOUNCE_GLITCH_CNT_EN.
module input_debouncer_2ch #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_a,
  input  logic raw_b,
  output logic a,
  output logic b,
  output logic a_changed,
  output logic b_changed,
  output logic stable
`ifdef DEBOUNCE_GLITCH_CNT_EN
  ,
  output logic [7:0] glitch_cnt
`endif
);

  typedef enum logic {ST_STABLE, ST_COUNTING} state_t;

  // Count value on which the next mismatching edge commits the new level.
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       raw;
  logic [1:0]       s1;
  logic [1:0]       s2;
  logic [1:0]       lvl;
  logic [1:0]       chg;
  logic [1:0]       will_count;
  state_t           state [2];
  logic [CNT_W-1:0] cnt   [2];

  assign raw = {raw_b, raw_a};

  // Next-cycle COUNTING flags, used so stable is registered alongside state.
  always_comb begin
    will_count = '0;
    for (int i = 0; i < 2; i++) begin
      if (state[i] == ST_STABLE) begin
        will_count[i] = (s2[i] != lvl[i]) && (LAST != '0);
      end else begin
        will_count[i] = (s2[i] != lvl[i]) && (cnt[i] != LAST);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1     <= '0;
      s2     <= '0;
      lvl    <= '0;
      chg    <= '0;
      stable <= 1'b1;
      for (int i = 0; i < 2; i++) begin
        state[i] <= ST_STABLE;
        cnt[i]   <= '0;
      end
    end else begin
      s1     <= raw;
      s2     <= s1;
      stable <= ~|will_count;
      for (int i = 0; i < 2; i++) begin
        chg[i] <= 1'b0;
        if (state[i] == ST_STABLE) begin
          if (s2[i] != lvl[i]) begin
            if (LAST == '0) begin
              lvl[i] <= s2[i];
              chg[i] <= 1'b1;
            end else begin
              state[i] <= ST_COUNTING;
              cnt[i]   <= CNT_W'(1);
            end
          end else begin
            cnt[i] <= '0;
          end
        end else begin
          if (s2[i] == lvl[i]) begin
            state[i] <= ST_STABLE;
            cnt[i]   <= '0;
          end else if (cnt[i] == LAST) begin
            lvl[i]   <= s2[i];
            chg[i]   <= 1'b1;
            state[i] <= ST_STABLE;
            cnt[i]   <= '0;
          end else begin
            cnt[i] <= cnt[i] + CNT_W'(1);
          end
        end
      end
    end
  end

  assign a         = lvl[0];
  assign b         = lvl[1];
  assign a_changed = chg[0];
  assign b_changed = chg[1];

`ifdef DEBOUNCE_GLITCH_CNT_EN
  logic [1:0] reject;
  logic [8:0] gsum;

  always_comb begin
    reject = '0;
    for (int i = 0; i < 2; i++) begin
      reject[i] = (state[i] == ST_COUNTING) && (s2[i] == lvl[i]);
    end
  end

  assign gsum = {1'b0, glitch_cnt} + {8'd0, reject[0]} + {8'd0, reject[1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      glitch_cnt <= 8'd0;
    end else begin
      glitch_cnt <= gsum[8] ? 8'hFF : gsum[7:0];
    end
  end
`endif

endmodule

// File: tb/tb_input_debouncer_2ch.sv
// Bench for input_debouncer_2ch: directed vector table, glitch saturation run, and random traffic vs a run-length model.
module tb_input_debouncer_2ch;
  localparam int D = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic raw_a = 1'b0;
  logic raw_b = 1'b0;
  logic a, b, a_changed, b_changed, stable;
`ifdef DEBOUNCE_GLITCH_CNT_EN
  logic [7:0] glitch_cnt;
`endif

  always #5 clk = ~clk;

  input_debouncer_2ch #(.DEBOUNCE_CYCLES(D), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .raw_a     (raw_a),
    .raw_b     (raw_b),
    .a         (a),
    .b         (b),
    .a_changed (a_changed),
    .b_changed (b_changed),
    .stable    (stable)
`ifdef DEBOUNCE_GLITCH_CNT_EN
    ,
    .glitch_cnt(glitch_cnt)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference: raw reaches the debouncer two edges late; out flips after D
  // consecutive mismatching edges; a mismatch run that ends early is a glitch.
  bit m_s1 [2];
  bit m_s2 [2];
  bit m_out[2];
  bit m_chg[2];
  int m_run[2];
  bit m_stable = 1'b1;
  int m_glitch = 0;

  task automatic model_edge(input bit r, input bit ra, input bit rb);
    bit raw_now[2];
    raw_now[0] = ra;
    raw_now[1] = rb;
    if (r) begin
      for (int c = 0; c < 2; c++) begin
        m_s1[c] = 0; m_s2[c] = 0; m_out[c] = 0; m_chg[c] = 0; m_run[c] = 0;
      end
      m_glitch = 0;
      m_stable = 1;
    end else begin
      for (int c = 0; c < 2; c++) begin
        m_chg[c] = 0;
        if (m_s2[c] != m_out[c]) begin
          m_run[c]++;
          if (m_run[c] == D) begin
            m_out[c] = m_s2[c];
            m_chg[c] = 1;
            m_run[c] = 0;
          end
        end else begin
          if (m_run[c] > 0) m_glitch = (m_glitch >= 255) ? 255 : m_glitch + 1;
          m_run[c] = 0;
        end
        m_s2[c] = m_s1[c];
        m_s1[c] = raw_now[c];
      end
      m_stable = (m_run[0] == 0) && (m_run[1] == 0);
    end
  endtask

  task automatic step(input bit r, input bit ra, input bit rb);
    rst   = r;
    raw_a = ra;
    raw_b = rb;
    @(posedge clk);
    #1;
    model_edge(r, ra, rb);
  endtask

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
  endtask

  function automatic logic [4:0] dut_vec();
    return {a, b, a_changed, b_changed, stable};
  endfunction

  function automatic logic [4:0] model_vec();
    return {m_out[0], m_out[1], m_chg[0], m_chg[1], m_stable};
  endfunction

  typedef struct {
    bit         r;
    bit         ra;
    bit         rb;
    logic [4:0] exp;   // {a, b, a_changed, b_changed, stable}
    int         eg;    // expected glitch_cnt
  } vec_t;

  vec_t tbl[$];

  task automatic add(input int n, input bit r, input bit ra, input bit rb,
                     input logic [4:0] exp, input int eg);
    vec_t v;
    v.r = r; v.ra = ra; v.rb = rb; v.exp = exp; v.eg = eg;
    for (int i = 0; i < n; i++) tbl.push_back(v);
  endtask

  initial begin
    // Reset and idle
    add(2, 1, 0, 0, 5'b00001, 0);
    add(3, 0, 0, 0, 5'b00001, 0);
    // Both channels rise together: k = first 11 row, outputs at k+5
    add(2, 0, 1, 1, 5'b00001, 0);
    add(3, 0, 1, 1, 5'b00000, 0);
    add(1, 0, 1, 1, 5'b11111, 0);
    add(1, 0, 1, 1, 5'b11001, 0);
    // b starts falling, reset lands mid-count with raw_a held high
    add(2, 0, 1, 0, 5'b11001, 0);
    add(1, 0, 1, 0, 5'b11000, 0);
    add(1, 1, 1, 0, 5'b00001, 0);
    // a re-rises 5 edges after the first edge with rst low
    add(2, 0, 1, 0, 5'b00001, 0);
    add(3, 0, 1, 0, 5'b00000, 0);
    add(1, 0, 1, 0, 5'b10101, 0);
    add(1, 0, 1, 0, 5'b10001, 0);
    // raw_b high for 3 cycles: rejected
    add(2, 0, 1, 1, 5'b10001, 0);
    add(1, 0, 1, 1, 5'b10000, 0);
    add(2, 0, 1, 0, 5'b10000, 0);
    add(2, 0, 1, 0, 5'b10001, 1);

    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].ra, tbl[i].rb);
      check($sformatf("vec[%0d]", i), 16'(dut_vec()), 16'(tbl[i].exp));
`ifdef DEBOUNCE_GLITCH_CNT_EN
      check($sformatf("vec_glitch[%0d]", i), 16'(glitch_cnt), 16'(tbl[i].eg));
`endif
    end

    // 300 rejected 2-cycle glitches on raw_a: a stays 0, count saturates
    step(1, 0, 0);
    step(1, 0, 0);
    for (int g = 0; g < 300; g++) begin
      step(0, 1, 0);
      step(0, 1, 0);
      for (int j = 0; j < 4; j++) step(0, 0, 0);
      check("glitch_run_a", 16'(a), 16'd0);
`ifdef DEBOUNCE_GLITCH_CNT_EN
      check("glitch_run_cnt", 16'(glitch_cnt), 16'((g + 1 > 255) ? 255 : g + 1));
`endif
    end

    // Random traffic against the model, occasional resets
    begin
      bit la, lb, rr;
      la = 0; lb = 0;
      step(1, 0, 0);
      for (int n = 0; n < 4000; n++) begin
        if ($urandom_range(0, 3) == 0) la = ~la;
        if ($urandom_range(0, 3) == 0) lb = ~lb;
        rr = ($urandom_range(0, 299) == 0);
        step(rr, la, lb);
        check("rand_vec", 16'(dut_vec()), 16'(model_vec()));
`ifdef DEBOUNCE_GLITCH_CNT_EN
        check("rand_glitch", 16'(glitch_cnt), 16'(m_glitch));
`endif
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
